fu_wb_arbiter: RTL and testbench
================================

Name: fu_wb_arbiter

Overview:
- Writeback stage downstream of the multi-cycle functional units (ALU, memory, MUL, DIV, JUMP).
- Each FU posts a completed result (destination register + 32-bit data) into its own small per-FU FIFO.
- A round-robin arbiter drains one result per cycle onto the single register-file write port.
- Backpressure (fu_full) tells the issue logic not to let a FU complete into a full queue.

Parameters:
- NUM_FU, 5, number of functional units feeding the arbiter (FU index 0..NUM_FU-1; memory FU is index 1).
- DEPTH, 2, entries per per-FU result FIFO (power of two, ≥2).
- XLEN, 32, data width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- fu_done  in  NUM_FU  per-FU one-cycle completion pulse.
- fu_rd  in  5*NUM_FU  packed destination register; FU i uses bits [5i+4:5i].
- fu_data  in  XLEN*NUM_FU  packed result; FU i uses bits [XLEN*i+XLEN-1:XLEN*i].
- fu_full  out  NUM_FU  FIFO i holds DEPTH entries (registered state).
- wb_en  out  1  register-file write enable.
- wb_rd  out  5  register-file write address.
- wb_data  out  XLEN  register-file write data.
- wb_fu  out  3  index of FU whose result is on wb_*.
- err_overflow  out  1  sticky: a fu_done arrived while that FIFO was full.

Behaviour:
- Reset (asynchronous):
  - All FIFOs empty; fu_full=0.
  - wb_en=0, wb_rd=0, wb_data=0, wb_fu=0, err_overflow=0.
  - Round-robin pointer=0.
  - Reset mid-operation discards all queued results; no wb_en pulse after rst deasserts until a new fu_done.
- Push: on a rising edge with fu_done[i]=1:
  - If fu_rd slice is 0, the result is discarded (x0 never written; counts unchanged).
  - Else if FIFO i is not full, or is full and is granted a pop this same cycle, the entry is written at the tail.
  - Else the entry is dropped and err_overflow is set (cleared only by rst).
- Arbitration (combinational, each cycle):
  - Candidates are FIFOs with count>0.
  - Grant goes to the first candidate at or after the pointer, wrapping modulo NUM_FU.
  - On a grant to FU g, the head is popped at the next edge and the pointer becomes (g+1) mod NUM_FU.
  - With no candidate, the pointer is unchanged.
- Output (registered):
  - At the edge where a pop occurs, wb_en=1, wb_rd/wb_data=head entry, wb_fu=g.
  - With no grant, wb_en=0 and wb_rd/wb_data/wb_fu hold their previous values.
  - wb_en is high for exactly one cycle per popped entry.
- Latency:
  - fu_done sampled at edge E0 with FIFO empty and no competitors: wb_en high in the cycle after E1 (2 edges).
  - Throughput: 1 result/cycle total.
- Simultaneous push and pop on the same FIFO:
  - Count unchanged and order preserved.
  - A FIFO holding 0 entries cannot be popped in the same cycle it is pushed; no bypass.
- Ordering: strict FIFO within each FU; no ordering guarantee across FUs.
- fu_full[i] = (count_i == DEPTH) and is based on registered count only.
- FIFO pointers: wrap modulo DEPTH; counts are 0..DEPTH.

Test Plan:
- Single result: FU1 done, rd=5, data=0xDEADBEEF, idle elsewhere -> 2 edges later wb_en=1 for 1 cycle, wb_rd=5, wb_data=0xDEADBEEF, wb_fu=1.
- Simultaneous: FU0 (rd=1, 0x11), FU1 (rd=2, 0x22) and FU3 (rd=3, 0x33) done in the same cycle after reset -> three consecutive wb_en cycles in order FU0, FU1, FU3, then wb_en=0.
- Fairness: FU0 and FU2 each done every cycle for 6 cycles -> grants alternate 0,2,0,2…; neither starves; fu_full never blocks both.
- Backpressure/overflow, step 1: with FU4 continuously granted, FU1 done twice (rd=7, 8) -> fu_full[1]=1 after the second push.
- Backpressure/overflow, step 2: a third FU1 done while full and not granted -> dropped, err_overflow=1 and stays 1; FU1's two entries still write back as rd 7 then 8.
- x0 discard: FU2 done with rd=0, data=0xFFFFFFFF -> no wb_en; queue count unchanged.
- Reset mid-operation: 3 FIFOs holding entries, assert rst asynchronously between edges -> wb_en=0 and fu_full=0 immediately; no writeback after release.

Source files
------------

// File: rtl/fu_wb_arbiter.sv
// Writeback arbiter: per-FU result FIFOs drained round-robin onto the single
// register-file write port, one result per cycle.
module fu_wb_arbiter #(
    parameter int NUM_FU = 5,
    parameter int DEPTH  = 2,
    parameter int XLEN   = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_FU-1:0]        fu_done,
    input  logic [5*NUM_FU-1:0]      fu_rd,
    input  logic [XLEN*NUM_FU-1:0]   fu_data,
    output logic [NUM_FU-1:0]        fu_full,
    output logic                     wb_en,
    output logic [4:0]               wb_rd,
    output logic [XLEN-1:0]          wb_data,
    output logic [2:0]               wb_fu,
    output logic                     err_overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [4:0]      q_rd   [NUM_FU][DEPTH];
    logic [XLEN-1:0] q_data [NUM_FU][DEPTH];
    logic [AW-1:0]   head   [NUM_FU];
    logic [AW-1:0]   tail   [NUM_FU];
    logic [CW-1:0]   count  [NUM_FU];
    logic [2:0]      rr_ptr;

    logic            gnt_vld;
    logic [2:0]      gnt_idx;
    logic [NUM_FU-1:0] pop;
    logic [NUM_FU-1:0] push;
    logic [NUM_FU-1:0] drop;

    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            fu_full[i] = (count[i] == CW'(DEPTH));
        end
    end

    // Round-robin search starting at the pointer, wrapping modulo NUM_FU.
    always_comb begin
        int idx;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int k = 0; k < NUM_FU; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_FU;
            if (!gnt_vld && (count[idx] != '0)) begin
                gnt_vld = 1'b1;
                gnt_idx = 3'(idx);
            end
        end
    end

    // A full FIFO still accepts a push when its head leaves on the same edge.
    always_comb begin
        pop  = '0;
        push = '0;
        drop = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            pop[i] = gnt_vld && (gnt_idx == 3'(i));
            if (fu_done[i] && (fu_rd[5*i +: 5] != 5'd0)) begin
                if (!fu_full[i] || pop[i]) begin
                    push[i] = 1'b1;
                end else begin
                    drop[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_FU; i++) begin
                head[i]  <= '0;
                tail[i]  <= '0;
                count[i] <= '0;
            end
            rr_ptr <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (push[i]) begin
                    tail[i] <= tail[i] + 1'b1;
                end
                if (pop[i]) begin
                    head[i] <= head[i] + 1'b1;
                end
                if (push[i] && !pop[i]) begin
                    count[i] <= count[i] + 1'b1;
                end else if (pop[i] && !push[i]) begin
                    count[i] <= count[i] - 1'b1;
                end
            end
            if (gnt_vld) begin
                rr_ptr <= (gnt_idx == 3'(NUM_FU - 1)) ? 3'd0 : gnt_idx + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (push[i]) begin
                q_rd[i][tail[i]]   <= fu_rd[5*i +: 5];
                q_data[i][tail[i]] <= fu_data[XLEN*i +: XLEN];
            end
        end
    end

    // Writeback register stage: head of the granted FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_en        <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            wb_fu        <= '0;
            err_overflow <= 1'b0;
        end else begin
            wb_en <= gnt_vld;
            if (gnt_vld) begin
                wb_rd   <= q_rd[gnt_idx][head[gnt_idx]];
                wb_data <= q_data[gnt_idx][head[gnt_idx]];
                wb_fu   <= gnt_idx;
            end
            if (drop != '0) begin
                err_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fu_wb_arbiter.sv
// Randomized scoreboard bench for fu_wb_arbiter against a queue-based model.
`timescale 1ns/1ps
module tb_fu_wb_arbiter;

    localparam int NUM_FU = 5;
    localparam int DEPTH  = 2;
    localparam int XLEN   = 32;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NUM_FU-1:0]      fu_done;
    logic [5*NUM_FU-1:0]    fu_rd;
    logic [XLEN*NUM_FU-1:0] fu_data;
    logic [NUM_FU-1:0]      fu_full;
    logic                   wb_en;
    logic [4:0]             wb_rd;
    logic [XLEN-1:0]        wb_data;
    logic [2:0]             wb_fu;
    logic                   err_overflow;

    fu_wb_arbiter #(.NUM_FU(NUM_FU), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .fu_done(fu_done), .fu_rd(fu_rd), .fu_data(fu_data),
        .fu_full(fu_full), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_fu(wb_fu), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } ent_t;

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
        int              fu;
        int              cyc;
    } exp_t;

    ent_t mq [NUM_FU][$];
    exp_t exp_q [$];
    int   m_ptr;
    logic m_err;
    int   cyc;
    int   errors;
    int   checks;
    logic in_reset;

    logic [NUM_FU-1:0]      p_done;
    logic [5*NUM_FU-1:0]    p_rd;
    logic [XLEN*NUM_FU-1:0] p_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic post(input int i, input logic [4:0] rd, input logic [XLEN-1:0] data);
        p_done[i]           = 1'b1;
        p_rd[5*i +: 5]      = rd;
        p_data[XLEN*i +: XLEN] = data;
    endtask

    // One cycle of the reference: serve the oldest entry of the first non-empty
    // FU at/after the pointer, then enqueue arrivals that fit.
    task automatic model_step();
        int   g;
        ent_t e;
        exp_t x;
        g = -1;
        for (int k = 0; k < NUM_FU; k++) begin
            if (g < 0 && mq[(m_ptr + k) % NUM_FU].size() > 0) g = (m_ptr + k) % NUM_FU;
        end
        if (g >= 0) begin
            e = mq[g].pop_front();
            x.rd = e.rd; x.data = e.data; x.fu = g; x.cyc = cyc + 1;
            exp_q.push_back(x);
            m_ptr = (g + 1) % NUM_FU;
        end
        for (int i = 0; i < NUM_FU; i++) begin
            if (fu_done[i] && fu_rd[5*i +: 5] != 5'd0) begin
                if (mq[i].size() < DEPTH) begin
                    e.rd = fu_rd[5*i +: 5];
                    e.data = fu_data[XLEN*i +: XLEN];
                    mq[i].push_back(e);
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        #2;
        fu_done = p_done;
        fu_rd   = p_rd;
        fu_data = p_data;
        p_done  = '0;
        p_rd    = '0;
        p_data  = '0;
        model_step();
    endtask

    task automatic model_clear();
        for (int i = 0; i < NUM_FU; i++) mq[i].delete();
        exp_q.delete();
        m_ptr = 0;
        m_err = 1'b0;
    endtask

    function automatic logic [NUM_FU-1:0] model_full();
        logic [NUM_FU-1:0] f;
        for (int i = 0; i < NUM_FU; i++) f[i] = (mq[i].size() == DEPTH);
        return f;
    endfunction

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor: every writeback must match the oldest expected entry and cycle.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (!in_reset) begin
                if (wb_en) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_wb: got wb_en=1 rd=%0d fu=%0d expected no write (t=%0t)",
                                 wb_rd, wb_fu, $time);
                    end else begin
                        x = exp_q.pop_front();
                        chk("wb_cycle", 64'(cyc), 64'(x.cyc));
                        chk("wb_rd", 64'(wb_rd), 64'(x.rd));
                        chk("wb_data", 64'(wb_data), 64'(x.data));
                        chk("wb_fu", 64'(wb_fu), 64'(x.fu));
                    end
                end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                    x = exp_q.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missing_wb: got wb_en=0 expected write rd=%0d fu=%0d (t=%0t)",
                             x.rd, x.fu, $time);
                end
                chk("fu_full", 64'(fu_full), 64'(model_full()));
                chk("err_overflow", 64'(err_overflow), 64'(m_err));
            end
        end
    end

    initial begin
        errors = 0; checks = 0;
        in_reset = 1'b1;
        rst = 1'b1;
        fu_done = '0; fu_rd = '0; fu_data = '0;
        p_done = '0; p_rd = '0; p_data = '0;
        model_clear();
        repeat (2) @(negedge clk);
        chk("rst_wb_en", 64'(wb_en), 64'd0);
        chk("rst_wb_rd", 64'(wb_rd), 64'd0);
        chk("rst_wb_data", 64'(wb_data), 64'd0);
        chk("rst_wb_fu", 64'(wb_fu), 64'd0);
        chk("rst_fu_full", 64'(fu_full), 64'd0);
        chk("rst_err", 64'(err_overflow), 64'd0);
        #2;
        rst = 1'b0;
        in_reset = 1'b0;

        // single result on the memory FU
        post(1, 5'd5, 32'hDEADBEEF); step();
        repeat (4) step();

        // three simultaneous completions
        post(0, 5'd1, 32'h11); post(1, 5'd2, 32'h22); post(3, 5'd3, 32'h33); step();
        repeat (5) step();

        // two contending FUs every cycle
        for (int c = 0; c < 6; c++) begin
            post(0, 5'(1 + c), $urandom); post(2, 5'(10 + c), $urandom); step();
        end
        repeat (8) step();

        // overflow: load other FUs, then FU1 completes three times back to back
        post(0, 5'd20, 32'hA0); post(2, 5'd21, 32'hA2);
        post(3, 5'd22, 32'hA3); post(4, 5'd23, 32'hA4); step();
        post(0, 5'd24, 32'hB0); post(2, 5'd25, 32'hB2);
        post(3, 5'd26, 32'hB3); post(4, 5'd27, 32'hB4); post(1, 5'd7, 32'h7); step();
        post(4, 5'd28, 32'hC4); post(1, 5'd8, 32'h8); step();
        post(4, 5'd29, 32'hD4); post(1, 5'd9, 32'h9); step();
        repeat (12) step();

        // x0 destination is discarded
        post(2, 5'd0, 32'hFFFFFFFF); step();
        repeat (4) step();

        // random traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NUM_FU; i++) begin
                if ($urandom_range(0, 99) < 35) post(i, 5'($urandom_range(0, 31)), $urandom);
            end
            step();
        end
        repeat (15) step();

        // reset mid-operation with several FIFOs occupied
        post(0, 5'd1, 32'h100); post(1, 5'd2, 32'h101); post(3, 5'd3, 32'h103); step();
        post(0, 5'd4, 32'h200); post(1, 5'd5, 32'h201); post(3, 5'd6, 32'h203); step();
        @(posedge clk);
        #3;
        in_reset = 1'b1;
        rst = 1'b1;
        fu_done = '0;
        model_clear();
        #1;
        chk("midrst_wb_en", 64'(wb_en), 64'd0);
        chk("midrst_fu_full", 64'(fu_full), 64'd0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        in_reset = 1'b0;
        repeat (6) step();

        // drain with a bounded budget
        for (int c = 0; c < 50 && exp_q.size() > 0; c++) step();
        chk("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
